bms_protection_ctrl: RTL and testbench
======================================

// Module: bms_protection_ctrl
// PURPOSE
//  Parametrised pack protection controller: next generation of the BMS protection FSM.
//  Takes per-cell OV/UV and per-sensor OT flags, a pack OC flag and SOC (0-100 %).
//  Debounces each fault class and applies SOC low/high thresholds with hysteresis.
//  Drives charge/discharge enables through INIT/NORMAL/CHARGE_ONLY/FAULT/COOLDOWN.
//  Faults latch with a sticky cause code; release only by fault_clr plus cooldown.
//  Sits between the threshold comparators and the contactor/gate-drive logic.
// PARAMETERS
//  N_CELLS      4   number of series cells (width of ov_fault/uv_fault)
//  N_TEMP       2   number of temperature sensors (width of ot_fault)
//  DEB_CYC      4   consecutive samples needed to qualify a fault class (>=1)
//  RECOVER_CYC  8   consecutive clean cycles needed for CHARGE_ONLY->NORMAL (>=1)
//  COOLDOWN_CYC 16  cycles held in COOLDOWN after an accepted clear (>=1)
//  SOC_LOW      10  SOC % at/below which low-SOC is set
//  SOC_HIGH     95  SOC % at/above which the raw high-SOC fault is set
//  SOC_HYST     3   low-SOC clears when soc_percent >= SOC_LOW+SOC_HYST
// PORTS
//  clk              in   1        clock
//  rst_n            in   1        reset, asynchronous, active-low
//  ov_fault         in   N_CELLS  per-cell overvoltage, raw
//  uv_fault         in   N_CELLS  per-cell undervoltage, raw
//  oc_fault         in   1        pack overcurrent, raw
//  ot_fault         in   N_TEMP   per-sensor overtemperature, raw
//  soc_percent      in   8        unsigned SOC; values >100 are treated as 100
//  fault_clr        in   1        single-cycle fault acknowledge
//  charge_en        out  1        charge path enable
//  discharge_en     out  1        discharge path enable
//  system_fault     out  1        high in FAULT and COOLDOWN
//  fault_code       out  4        sticky cause {SOCH,OT,OC,OV}, bits [3:0]
//  state_o          out  3        current state encoding, for debug
// BEHAVIOUR
//  Reset: state=INIT; all counters 0; low-SOC flag 0; every output 0.
//  Class raw = OR-reduce: OV=|ov_fault, UV=|uv_fault, OT=|ot_fault, OC=oc_fault,
//   SOCH = soc>=SOC_HIGH.
//  Debounce per class (OV, UV, OC, OT, SOCH):
//   - counter +1 on each edge raw=1, saturating at DEB_CYC; cleared to 0 on any edge raw=0.
//   - qual = (cnt==DEB_CYC), registered.
//   - Raw high first sampled at edge k -> qual high after edge k+DEB_CYC-1
//     -> state change at edge k+DEB_CYC.
//  Low-SOC flag, registered: set when soc<=SOC_LOW; cleared when soc>=SOC_LOW+SOC_HYST;
//   holds otherwise. Not debounced.
//  Outputs are Moore, decoded from state: zero extra latency.
//  Hard fault HF = qual_OV | qual_OC | qual_OT | qual_SOCH.
//  Soft SF = qual_UV | low_soc.
//  INIT: chg=0 dis=0. HF->FAULT; else ->NORMAL (one cycle).
//  NORMAL: chg=1 dis=1. HF->FAULT; else SF->CHARGE_ONLY.
//  CHARGE_ONLY: chg=1 dis=0. HF->FAULT (HF has priority over recovery).
//   - Recovery counter counts cycles with SF=0 and clears whenever SF=1.
//   - Counter reaching RECOVER_CYC ->NORMAL; counter cleared on entry.
//  FAULT: chg=0 dis=0 sys=1. fault_code |= HF class vector on the entry edge
//   and on every cycle while in FAULT.
//   - fault_clr=1 with HF=0 that cycle ->COOLDOWN.
//   - fault_clr with HF=1 is ignored; it is not remembered.
//  COOLDOWN: chg=0 dis=0 sys=1; timer counts COOLDOWN_CYC cycles, then ->INIT.
//   - fault_code cleared on exit to INIT.
//   - HF re-qualifying during cooldown ->FAULT: timer reset, code bits ORed.
//  fault_clr outside FAULT: no effect.
//  Illegal state encoding ->INIT.
//  Reset mid-operation returns to INIT immediately, regardless of state.
//  Counter widths = $clog2(param+1); no counter wraps, all saturate.
// STRUCTURE
//  Package bms_prot_pkg:
//   - state encodings INIT=0, NORMAL=1, CHARGE_ONLY=2, FAULT=3, COOLDOWN=4.
//   - fault_code bit indices FC_OV=0, FC_OC=1, FC_OT=2, FC_SOCH=3.
//  Sub-module fault_debounce #(DEB_CYC) (clk, rst_n, raw, qual): five instances.
//  Top holds SOC hysteresis, recovery/cooldown counters, FSM, output decode.
// TESTING  (default parameters)
//  1 Reset: all outputs 0; one cycle later NORMAL, chg=dis=1.
//  2 ov_fault=4'b0100 for 3 cycles then 0 -> no state change.
//    Held 4 cycles -> FAULT on the 4th edge after first sample, fault_code=4'b0001.
//  3 SOC 50->10 -> CHARGE_ONLY (chg=1, dis=0).
//    SOC=12 -> stays CHARGE_ONLY.
//    SOC=13 -> NORMAL exactly 8 clean cycles later.
//  4 In CHARGE_ONLY, oc_fault and uv_fault both held -> FAULT, fault_code=4'b0010.
//  5 In FAULT: fault_clr while ot_fault still high -> ignored.
//    ot_fault drops (qual low), fault_clr -> COOLDOWN for 16 cycles -> INIT, fault_code=0
//    -> NORMAL.
//  6 soc=98 during COOLDOWN -> FAULT, fault_code bit3 set.
//    rst_n asserted mid-COOLDOWN -> INIT with outputs 0 asynchronously.

Source files
------------

// File: rtl/bms_prot_pkg.sv
// Shared types for the pack protection controller: state encoding, fault-code bit map, SOC clamp.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bms_prot_pkg;

  // Encodings are visible on state_o, so they are fixed values rather than tool-chosen.
  typedef enum logic [2:0] {
    ST_INIT        = 3'd0,
    ST_NORMAL      = 3'd1,
    ST_CHARGE_ONLY = 3'd2,
    ST_FAULT       = 3'd3,
    ST_COOLDOWN    = 3'd4
  } state_t;

  // Bit positions inside fault_code.
  localparam int FC_OV   = 0;
  localparam int FC_OC   = 1;
  localparam int FC_OT   = 2;
  localparam int FC_SOCH = 3;

  // SOC readings above 100 % are sensor overshoot; treat them as full.
  function automatic logic [7:0] soc_clamp(input logic [7:0] soc);
    return (soc > 8'd100) ? 8'd100 : soc;
  endfunction

endpackage

// File: rtl/bms_protection_ctrl_if.sv
// Bundle between threshold comparators (master) and the protection controller (slave).
// Latency: wires only.
// Backpressure: none; flags are level signals sampled every clock.
// Ports: ov/uv per cell, oc pack, ot per sensor, soc_percent, fault_clr in;
//        charge_en, discharge_en, system_fault, fault_code, state_o out.
interface bms_protection_ctrl_if #(
  parameter int N_CELLS = 4,
  parameter int N_TEMP  = 2
);
  logic [N_CELLS-1:0] ov_fault;
  logic [N_CELLS-1:0] uv_fault;
  logic               oc_fault;
  logic [N_TEMP-1:0]  ot_fault;
  logic [7:0]         soc_percent;
  logic               fault_clr;
  logic               charge_en;
  logic               discharge_en;
  logic               system_fault;
  logic [3:0]         fault_code;
  logic [2:0]         state_o;

  modport master (
    output ov_fault, uv_fault, oc_fault, ot_fault, soc_percent, fault_clr,
    input  charge_en, discharge_en, system_fault, fault_code, state_o
  );

  modport slave (
    input  ov_fault, uv_fault, oc_fault, ot_fault, soc_percent, fault_clr,
    output charge_en, discharge_en, system_fault, fault_code, state_o
  );
endinterface

// File: rtl/fault_debounce.sv
// Qualifies one raw fault flag after DEB_CYC consecutive high samples.
// Latency: qual rises after the DEB_CYC-th consecutive high edge; drops one edge after raw low.
// Backpressure: none.
// Ports: clk, rst_n (async, active-low), raw in, qual out (registered).
module fault_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic qual
);
  localparam int            CW      = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Any low sample restarts the run; the count saturates so a held fault stays qualified.
  always_comb begin
    cnt_nxt = '0;
    if (raw) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      qual <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      qual <= (cnt_nxt == CNT_MAX);
    end
  end
endmodule

// File: rtl/bms_protection_ctrl.sv
// Pack protection FSM: debounced fault classes + SOC hysteresis drive charge/discharge enables.
// Latency: outputs are registered from the next state, so they change on the same edge as state.
// Backpressure: none; fault_clr is a single-cycle pulse, honoured only in FAULT with no hard fault.
// Ports: clk, rst_n (async, active-low), bus (slave modport of bms_protection_ctrl_if).
module bms_protection_ctrl
  import bms_prot_pkg::*;
#(
  parameter int N_CELLS      = 4,
  parameter int N_TEMP       = 2,
  parameter int DEB_CYC      = 4,
  parameter int RECOVER_CYC  = 8,
  parameter int COOLDOWN_CYC = 16,
  parameter int SOC_LOW      = 10,
  parameter int SOC_HIGH     = 95,
  parameter int SOC_HYST     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bms_protection_ctrl_if.slave  bus
);
  localparam int               RW         = $clog2(RECOVER_CYC + 1);
  localparam int               TW         = $clog2(COOLDOWN_CYC + 1);
  localparam logic [RW-1:0]    REC_LAST   = RW'(RECOVER_CYC - 1);
  localparam logic [TW-1:0]    CD_LAST    = TW'(COOLDOWN_CYC - 1);
  localparam logic [7:0]       SOC_LOW_V  = 8'(SOC_LOW);
  localparam logic [7:0]       SOC_CLR_V  = 8'(SOC_LOW + SOC_HYST);
  localparam logic [7:0]       SOC_HIGH_V = 8'(SOC_HIGH);

  logic [7:0]    soc_c;
  logic          q_ov, q_uv, q_oc, q_ot, q_soch;
  logic          low_soc;
  logic [3:0]    hf_vec;
  logic          hf, sf;
  state_t        state, state_nxt;
  logic [RW-1:0] rec_cnt, rec_nxt;
  logic [TW-1:0] cd_tmr, cd_nxt;
  logic [3:0]    code_q, code_nxt;
  logic          chg_q, dis_q, sys_q;

  assign soc_c = soc_clamp(bus.soc_percent);

  fault_debounce #(.DEB_CYC(DEB_CYC)) u_deb_ov (
    .clk(clk), .rst_n(rst_n), .raw(|bus.ov_fault[N_CELLS-1:0]), .qual(q_ov));
  fault_debounce #(.DEB_CYC(DEB_CYC)) u_deb_uv (
    .clk(clk), .rst_n(rst_n), .raw(|bus.uv_fault[N_CELLS-1:0]), .qual(q_uv));
  fault_debounce #(.DEB_CYC(DEB_CYC)) u_deb_oc (
    .clk(clk), .rst_n(rst_n), .raw(bus.oc_fault), .qual(q_oc));
  fault_debounce #(.DEB_CYC(DEB_CYC)) u_deb_ot (
    .clk(clk), .rst_n(rst_n), .raw(|bus.ot_fault[N_TEMP-1:0]), .qual(q_ot));
  fault_debounce #(.DEB_CYC(DEB_CYC)) u_deb_soch (
    .clk(clk), .rst_n(rst_n), .raw(soc_c >= SOC_HIGH_V), .qual(q_soch));

  // Low-SOC flag: the band between set and clear thresholds holds the previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  low_soc <= 1'b0;
    else if (soc_c <= SOC_LOW_V) low_soc <= 1'b1;
    else if (soc_c >= SOC_CLR_V) low_soc <= 1'b0;
  end

  always_comb begin
    hf_vec          = '0;
    hf_vec[FC_OV]   = q_ov;
    hf_vec[FC_OC]   = q_oc;
    hf_vec[FC_OT]   = q_ot;
    hf_vec[FC_SOCH] = q_soch;
  end
  assign hf = |hf_vec;
  assign sf = q_uv | low_soc;

  always_comb begin
    state_nxt = state;
    rec_nxt   = rec_cnt;
    cd_nxt    = cd_tmr;
    code_nxt  = code_q;
    case (state)
      ST_INIT:        state_nxt = hf ? ST_FAULT : ST_NORMAL;
      ST_NORMAL: begin
        if (hf)      state_nxt = ST_FAULT;
        else if (sf) state_nxt = ST_CHARGE_ONLY;
      end
      ST_CHARGE_ONLY: begin
        if (hf)                       state_nxt = ST_FAULT;
        else if (sf)                  rec_nxt   = '0;
        else if (rec_cnt == REC_LAST) state_nxt = ST_NORMAL;
        else                          rec_nxt   = rec_cnt + RW'(1);
      end
      ST_FAULT: begin
        // A clear seen while a hard fault is still qualified is simply dropped.
        if (bus.fault_clr && !hf) state_nxt = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (hf)                     state_nxt = ST_FAULT;
        else if (cd_tmr == CD_LAST) state_nxt = ST_INIT;
        else                        cd_nxt    = cd_tmr + TW'(1);
      end
      default:        state_nxt = ST_INIT;
    endcase
    // Counters only live inside their own state, so leaving clears them for the next entry.
    if (state_nxt != ST_CHARGE_ONLY) rec_nxt = '0;
    if (state_nxt != ST_COOLDOWN)    cd_nxt  = '0;
    if (state_nxt == ST_FAULT)       code_nxt = code_q | hf_vec;
    if (state_nxt == ST_INIT)        code_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      rec_cnt <= '0;
      cd_tmr  <= '0;
      code_q  <= '0;
      chg_q   <= 1'b0;
      dis_q   <= 1'b0;
      sys_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rec_cnt <= rec_nxt;
      cd_tmr  <= cd_nxt;
      code_q  <= code_nxt;
      chg_q   <= (state_nxt == ST_NORMAL) || (state_nxt == ST_CHARGE_ONLY);
      dis_q   <= (state_nxt == ST_NORMAL);
      sys_q   <= (state_nxt == ST_FAULT) || (state_nxt == ST_COOLDOWN);
    end
  end

  assign bus.charge_en    = chg_q;
  assign bus.discharge_en = dis_q;
  assign bus.system_fault = sys_q;
  assign bus.fault_code   = code_q;
  assign bus.state_o      = state;
endmodule

// File: tb/tb_bms_protection_ctrl.sv
// Bench for bms_protection_ctrl: directed scenarios then randomized traffic against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bms_protection_ctrl;
  localparam int N_CELLS = 4, N_TEMP = 2, DEB = 4, REC = 8, CDN = 16;
  localparam int SLOW = 10, SHIGH = 95, SHYS = 3;
  localparam int S_INIT = 0, S_NORMAL = 1, S_CHG = 2, S_FAULT = 3, S_COOL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  bms_protection_ctrl_if #(.N_CELLS(N_CELLS), .N_TEMP(N_TEMP)) bus ();

  bms_protection_ctrl #(
    .N_CELLS(N_CELLS), .N_TEMP(N_TEMP), .DEB_CYC(DEB), .RECOVER_CYC(REC),
    .COOLDOWN_CYC(CDN), .SOC_LOW(SLOW), .SOC_HIGH(SHIGH), .SOC_HYST(SHYS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: run[] = length of the current unbroken run of high samples per class
  // (0 OV, 1 UV, 2 OC, 3 OT, 4 SOCH); a class is qualified once its run reaches DEB.
  int         run[5];
  bit         m_low;
  int         m_st, m_rec, m_cd;
  logic [3:0] m_code;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) run[i] = 0;
    m_low = 0; m_st = S_INIT; m_rec = 0; m_cd = 0; m_code = '0;
  endtask

  task automatic model_step();
    int         soc;
    bit         q[5];
    bit         r[5];
    logic [3:0] hv;
    bit         hf, sf;
    for (int i = 0; i < 5; i++) q[i] = (run[i] >= DEB);
    hv = {q[4], q[3], q[2], q[0]};
    hf = |hv;
    sf = q[1] | m_low;
    case (m_st)
      S_INIT:   m_st = hf ? S_FAULT : S_NORMAL;
      S_NORMAL: if (hf) m_st = S_FAULT; else if (sf) begin m_st = S_CHG; m_rec = 0; end
      S_CHG: begin
        if (hf) m_st = S_FAULT;
        else if (sf) m_rec = 0;
        else begin m_rec++; if (m_rec == REC) m_st = S_NORMAL; end
      end
      S_FAULT:  if (bus.fault_clr && !hf) begin m_st = S_COOL; m_cd = 0; end
      default: begin
        if (hf) m_st = S_FAULT;
        else begin m_cd++; if (m_cd == CDN) begin m_st = S_INIT; m_code = '0; end end
      end
    endcase
    if (m_st == S_FAULT) m_code = m_code | hv;
    soc  = (int'(bus.soc_percent) > 100) ? 100 : int'(bus.soc_percent);
    r[0] = |bus.ov_fault; r[1] = |bus.uv_fault; r[2] = bus.oc_fault;
    r[3] = |bus.ot_fault; r[4] = (soc >= SHIGH);
    for (int i = 0; i < 5; i++) run[i] = r[i] ? run[i] + 1 : 0;
    if (soc <= SLOW) m_low = 1;
    else if (soc >= SLOW + SHYS) m_low = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".state"}, 8'(bus.state_o), 8'(m_st));
    chk({tag, ".chg"}, 8'(bus.charge_en), 8'(m_st == S_NORMAL || m_st == S_CHG));
    chk({tag, ".dis"}, 8'(bus.discharge_en), 8'(m_st == S_NORMAL));
    chk({tag, ".sys"}, 8'(bus.system_fault), 8'(m_st == S_FAULT || m_st == S_COOL));
    chk({tag, ".code"}, 8'(bus.fault_code), 8'(m_code));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check("cyc");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [7:0] soc_tab[11] = '{8'd5, 8'd10, 8'd11, 8'd12, 8'd13, 8'd50,
                              8'd80, 8'd95, 8'd98, 8'd120, 8'd200};

  initial begin
    bus.ov_fault = '0; bus.uv_fault = '0; bus.oc_fault = 1'b0; bus.ot_fault = '0;
    bus.soc_percent = 8'd50; bus.fault_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_state", 8'(bus.state_o), 8'd0);
    chk("rst_chg", 8'(bus.charge_en), 8'd0);
    chk("rst_dis", 8'(bus.discharge_en), 8'd0);
    chk("rst_sys", 8'(bus.system_fault), 8'd0);
    chk("rst_code", 8'(bus.fault_code), 8'd0);
    rst_n = 1'b1;
    tick();
    chk("t1_normal", 8'(bus.state_o), 8'(S_NORMAL));
    chk("t1_chg", 8'(bus.charge_en), 8'd1);
    chk("t1_dis", 8'(bus.discharge_en), 8'd1);

    // OV glitch shorter than the debounce window, then a qualifying one.
    bus.ov_fault = 4'b0100; ticks(3);
    bus.ov_fault = '0; tick();
    chk("t2_glitch", 8'(bus.state_o), 8'(S_NORMAL));
    bus.ov_fault = 4'b0100; ticks(4);
    chk("t2_pre", 8'(bus.state_o), 8'(S_NORMAL));
    tick();
    chk("t2_fault", 8'(bus.state_o), 8'(S_FAULT));
    chk("t2_code", 8'(bus.fault_code), 8'h1);
    bus.ov_fault = '0; tick();
    bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
    chk("t2_cool", 8'(bus.state_o), 8'(S_COOL));
    ticks(CDN - 1);
    chk("t2_cool_end", 8'(bus.state_o), 8'(S_COOL));
    tick();
    chk("t2_init", 8'(bus.state_o), 8'(S_INIT));
    chk("t2_init_code", 8'(bus.fault_code), 8'h0);
    tick();
    chk("t2_normal", 8'(bus.state_o), 8'(S_NORMAL));

    // Low SOC with hysteresis and timed recovery.
    bus.soc_percent = 8'd10; ticks(2);
    chk("t3_co", 8'(bus.state_o), 8'(S_CHG));
    chk("t3_dis", 8'(bus.discharge_en), 8'd0);
    bus.soc_percent = 8'd12; ticks(3);
    chk("t3_hold", 8'(bus.state_o), 8'(S_CHG));
    bus.soc_percent = 8'd13; ticks(REC);
    chk("t3_rec_pre", 8'(bus.state_o), 8'(S_CHG));
    tick();
    chk("t3_rec", 8'(bus.state_o), 8'(S_NORMAL));

    // Hard fault has priority in CHARGE_ONLY; UV only contributes to soft fault.
    bus.soc_percent = 8'd10; ticks(2);
    chk("t4_co", 8'(bus.state_o), 8'(S_CHG));
    bus.oc_fault = 1'b1; bus.uv_fault = 4'b0011; ticks(DEB);
    chk("t4_pre", 8'(bus.state_o), 8'(S_CHG));
    tick();
    chk("t4_fault", 8'(bus.state_o), 8'(S_FAULT));
    chk("t4_code", 8'(bus.fault_code), 8'h2);

    // Clear ignored while OT qualified, and not remembered afterwards.
    bus.oc_fault = 1'b0; bus.uv_fault = '0; bus.soc_percent = 8'd50; bus.ot_fault = 2'b10;
    ticks(DEB);
    bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
    chk("t5_ignored", 8'(bus.state_o), 8'(S_FAULT));
    tick();
    chk("t5_not_kept", 8'(bus.state_o), 8'(S_FAULT));
    bus.ot_fault = '0; tick();
    bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
    chk("t5_cool", 8'(bus.state_o), 8'(S_COOL));
    chk("t5_code", 8'(bus.fault_code), 8'h6);
    ticks(CDN);
    chk("t5_init_code", 8'(bus.fault_code), 8'h0);
    tick();
    chk("t5_normal", 8'(bus.state_o), 8'(S_NORMAL));

    // High SOC re-faults during cooldown, then async reset mid-cooldown.
    bus.ov_fault = 4'b0001; ticks(DEB + 1);
    bus.ov_fault = '0; tick();
    bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
    ticks(2);
    bus.soc_percent = 8'd98; ticks(DEB);
    chk("t6_cool", 8'(bus.state_o), 8'(S_COOL));
    tick();
    chk("t6_refault", 8'(bus.state_o), 8'(S_FAULT));
    chk("t6_code", 8'(bus.fault_code), 8'h9);
    bus.soc_percent = 8'd50; tick();
    bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
    ticks(3);
    chk("t6_cool2", 8'(bus.state_o), 8'(S_COOL));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_state", 8'(bus.state_o), 8'd0);
    chk("t6_arst_sys", 8'(bus.system_fault), 8'd0);
    chk("t6_arst_code", 8'(bus.fault_code), 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic: fault patterns held for a few cycles, random clears and SOC levels.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.ov_fault    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
        bus.uv_fault    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : '0;
        bus.oc_fault    = ($urandom_range(0, 9) == 0);
        bus.ot_fault    = ($urandom_range(0, 9) == 0) ? 2'($urandom) : '0;
        bus.soc_percent = soc_tab[$urandom_range(0, 10)];
      end
      bus.fault_clr = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
